// File: rtl/game_tick_ctrl_pkg.sv
// game_tick_ctrl_pkg
//   Shared definitions for the game tick front end and the state logic it feeds.
//   It holds the state width and the state encodings.
//   INIT must stay at 0 because reset loads it and the frame counter keys off it.
package game_tick_ctrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    INIT                   = 4'd0,
    DRAW_BOARD             = 4'd1,
    GENERATE               = 4'd2,
    MOVE_ONE_DOWN          = 4'd3,
    MOVE_LEFT              = 4'd4,
    MOVE_RIGHT             = 4'd5,
    SPIN_LEFT              = 4'd6,
    HIT_BOTTOM             = 4'd7,
    CHECK_COMPLETE_ROW     = 4'd8,
    DELETE_ROW             = 4'd9,
    SHIFT_ALL_BLOCKS_ABOVE = 4'd10,
    GAME_OVER              = 4'd11
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_tick_ctrl_if.sv
// game_tick_ctrl_if
//   Bundle between the tick controller and the combinational state/draw logic.
//   Signals:
//     frame_end  : 1-cycle pulse from the VGA timing at the first vblank line
//     ns         : next state produced by the state logic
//     s          : registered current state fed to the state logic
//     drop_tick  : gravity pulse
//     move_left  : move pulse
//     move_right : move pulse
//     spin_left  : move pulse
//   Modports:
//     master : the tick controller (drives s and the pulses)
//     slave  : the state logic / timing side
interface game_tick_ctrl_if;
  import game_tick_ctrl_pkg::*;

  logic               frame_end;
  logic [STATE_W-1:0] ns;
  logic [STATE_W-1:0] s;
  logic               drop_tick;
  logic               move_left;
  logic               move_right;
  logic               spin_left;

  modport master (
    input  frame_end, ns,
    output s, drop_tick, move_left, move_right, spin_left
  );

  modport slave (
    output frame_end, ns,
    input  s, drop_tick, move_left, move_right, spin_left
  );
endinterface

// File: rtl/game_tick_ctrl_btn_debounce.sv
// btn_debounce
//   Takes one raw asynchronous button through a 2-flop synchronizer and a stable-level
//   debouncer. It produces a 1-cycle pulse on each rising edge of the debounced level.
//   Parameters:
//     CYCLES : consecutive cycles the synced level must differ before level follows
//   Ports:
//     clk   in  clock
//     rst   in  synchronous active-high reset
//     btn   in  raw button, asynchronous
//     level out debounced level
//     rise  out 1-cycle pulse, registered, on the debounced 0->1 transition
module btn_debounce
  import game_tick_ctrl_pkg::*;
#(
  parameter int CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(CYCLES + 1);

  logic             meta_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      rise    <= 1'b0;
      cnt     <= '0;
    end else begin
      // synchronizer stages
      meta_p0 <= btn;
      sync_p1 <= meta_p0;
      rise    <= 1'b0;
      // Any cycle where the synced level agrees with level restarts the count.
      if (sync_p1 != level) begin
        if (cnt == CNT_W'(CYCLES - 1)) begin
          level <= sync_p1;
          rise  <= sync_p1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/game_tick_ctrl.sv
// game_tick_ctrl
//   This block is the sequential front end of the game state logic.
//   - It registers the state s from ns, and s only advances on frame_end.
//   - It generates the gravity drop_tick from a frame counter.
//   - It turns debounced button presses into frame-aligned move pulses.
//   All outputs are registered and change on the edge that samples frame_end.
//   Optional build macro: FAST_DROP_EN. It adds the btn_down port.
//   While down is held, the drop period becomes FAST_DROP_FRAMES.
//   Ports:
//     clk        in  pixel clock
//     rst        in  synchronous active-high reset
//     tick       master modport of game_tick_ctrl_if (frame_end, ns, s, pulses)
//     btn_left   in  raw button
//     btn_right  in  raw button
//     btn_rot    in  raw button
//     btn_down   in  raw button (FAST_DROP_EN only)
module game_tick_ctrl
  import game_tick_ctrl_pkg::*;
#(
  parameter int DROP_FRAMES     = 30,
  parameter int DEBOUNCE_CYCLES = 250000
`ifdef FAST_DROP_EN
  ,
  parameter int FAST_DROP_FRAMES = 3
`endif
) (
  input  logic              clk,
  input  logic              rst,
  game_tick_ctrl_if.master  tick,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_rot
`ifdef FAST_DROP_EN
  ,
  input  logic              btn_down
`endif
);

`ifdef FAST_DROP_EN
  localparam int PERIOD_MAX = max_int(DROP_FRAMES, FAST_DROP_FRAMES);
`else
  localparam int PERIOD_MAX = DROP_FRAMES;
`endif
  localparam int FCNT_W = $clog2(PERIOD_MAX + 1);

  logic [FCNT_W-1:0] fcnt;
  logic [FCNT_W-1:0] period_m1;
  logic              rise_left, rise_right, rise_rot;
  logic [2:0]        unused_lvl;
  logic              pend_left, pend_right, pend_rot;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk(clk), .rst(rst), .btn(btn_left), .level(unused_lvl[0]), .rise(rise_left)
  );
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk(clk), .rst(rst), .btn(btn_right), .level(unused_lvl[1]), .rise(rise_right)
  );
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_rot (
    .clk(clk), .rst(rst), .btn(btn_rot), .level(unused_lvl[2]), .rise(rise_rot)
  );

`ifdef FAST_DROP_EN
  logic down_lvl;
  logic unused_down_rise;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk(clk), .rst(rst), .btn(btn_down), .level(down_lvl), .rise(unused_down_rise)
  );

  assign period_m1 = down_lvl ? FCNT_W'(FAST_DROP_FRAMES - 1) : FCNT_W'(DROP_FRAMES - 1);
`else
  assign period_m1 = FCNT_W'(DROP_FRAMES - 1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tick.s          <= INIT;
      tick.drop_tick  <= 1'b0;
      tick.move_left  <= 1'b0;
      tick.move_right <= 1'b0;
      tick.spin_left  <= 1'b0;
      fcnt            <= '0;
      pend_left       <= 1'b0;
      pend_right      <= 1'b0;
      pend_rot        <= 1'b0;
    end else begin
      if (tick.frame_end) begin
        tick.s <= tick.ns;
      end

      // The >= compare covers a drop-period shrink that leaves fcnt past the new end.
      tick.drop_tick <= 1'b0;
      if (tick.s == INIT) begin
        fcnt <= '0;
      end else if (tick.frame_end) begin
        if (fcnt >= period_m1) begin
          tick.drop_tick <= 1'b1;
          fcnt           <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end

      // Opposite moves pending in one frame cancel each other.
      tick.move_left  <= tick.frame_end & pend_left & ~pend_right;
      tick.move_right <= tick.frame_end & pend_right & ~pend_left;
      tick.spin_left  <= tick.frame_end & pend_rot;

      // A rise landing on the frame_end cycle survives the clear for the next frame.
      if (tick.frame_end) begin
        pend_left  <= rise_left;
        pend_right <= rise_right;
        pend_rot   <= rise_rot;
      end else begin
        pend_left  <= pend_left | rise_left;
        pend_right <= pend_right | rise_right;
        pend_rot   <= pend_rot | rise_rot;
      end
    end
  end

endmodule

// File: tb/tb_game_tick_ctrl.sv
module tb_game_tick_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic btn_left, btn_right, btn_rot;
`ifdef FAST_DROP_EN
  logic btn_down;
`endif

  int checks = 0;
  int errors = 0;

  game_tick_ctrl_if bus ();

  game_tick_ctrl #(
    .DROP_FRAMES(4),
    .DEBOUNCE_CYCLES(8)
`ifdef FAST_DROP_EN
    ,
    .FAST_DROP_FRAMES(2)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(bus),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_rot(btn_rot)
`ifdef FAST_DROP_EN
    ,
    .btn_down(btn_down)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame of 100 clocks, beginning with the frame_end cycle. The first slot
  // holds pulse values right after the frame_end edge {drop,left,right,spin}.
  // The remaining outputs are pulse counts over the whole frame.
  task automatic do_frame(output int nd, output int nl, output int nr, output int nsp,
                          output logic [3:0] first);
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    first = {bus.drop_tick, bus.move_left, bus.move_right, bus.spin_left};
    nd = int'(bus.drop_tick); nl = int'(bus.move_left);
    nr = int'(bus.move_right); nsp = int'(bus.spin_left);
    for (int i = 0; i < 99; i++) begin
      tick();
      nd += int'(bus.drop_tick); nl += int'(bus.move_left);
      nr += int'(bus.move_right); nsp += int'(bus.spin_left);
    end
  endtask

  task automatic test_reset();
    int nd, nl, nr, nsp;
    logic [3:0] first;
    rst = 1'b1;
    bus.ns = 4'd2;
    repeat (3) tick();
    checks++;
    if (bus.s !== 4'd0) begin
      errors++; $display("FAIL reset_s: got %0d expected 0", bus.s);
    end
    checks++;
    if ({bus.drop_tick, bus.move_left, bus.move_right, bus.spin_left} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pulses: got %b expected 0000",
               {bus.drop_tick, bus.move_left, bus.move_right, bus.spin_left});
    end
    rst = 1'b0;
    repeat (5) tick();
    checks++;
    if (bus.s !== 4'd0) begin
      errors++; $display("FAIL s_hold_before_frame: got %0d expected 0", bus.s);
    end
    do_frame(nd, nl, nr, nsp, first);
    checks++;
    if (bus.s !== 4'd2) begin
      errors++; $display("FAIL s_after_first_frame: got %0d expected 2", bus.s);
    end
    checks++;
    if (nd != 0) begin
      errors++; $display("FAIL drop_in_init_frame: got %0d expected 0", nd);
    end
  endtask

  task automatic test_drop();
    int nd, nl, nr, nsp, exp_d;
    logic [3:0] first;
    for (int f = 1; f <= 12; f++) begin
      do_frame(nd, nl, nr, nsp, first);
      exp_d = (f % 4 == 0) ? 1 : 0;
      checks++;
      if (nd != exp_d || int'(first[3]) != exp_d) begin
        errors++;
        $display("FAIL drop_frame%0d: got count %0d first %b expected %0d", f, nd, first[3], exp_d);
      end
    end
    bus.ns = 4'd0;
    do_frame(nd, nl, nr, nsp, first);
    checks++;
    if (bus.s !== 4'd0) begin
      errors++; $display("FAIL s_to_init: got %0d expected 0", bus.s);
    end
    for (int f = 1; f <= 3; f++) begin
      do_frame(nd, nl, nr, nsp, first);
      checks++;
      if (nd != 0) begin
        errors++; $display("FAIL drop_in_init%0d: got %0d expected 0", f, nd);
      end
    end
    bus.ns = 4'd2;
    do_frame(nd, nl, nr, nsp, first);
    for (int f = 1; f <= 4; f++) begin
      do_frame(nd, nl, nr, nsp, first);
      exp_d = (f == 4) ? 1 : 0;
      checks++;
      if (nd != exp_d) begin
        errors++; $display("FAIL drop_after_init%0d: got %0d expected %0d", f, nd, exp_d);
      end
    end
  endtask

  task automatic test_move();
    int nd, nl, nr, nsp;
    logic [3:0] first;
    btn_left = 1'b1;
    repeat (20) tick();
    btn_left = 1'b0;
    repeat (12) tick();
    do_frame(nd, nl, nr, nsp, first);
    checks++;
    if (nl != 1 || first[2] !== 1'b1 || nr != 0 || nsp != 0) begin
      errors++;
      $display("FAIL clean_left: got l=%0d first=%b r=%0d sp=%0d expected l=1 first=1 r=0 sp=0",
               nl, first[2], nr, nsp);
    end
    do_frame(nd, nl, nr, nsp, first);
    checks++;
    if (nl != 0) begin
      errors++; $display("FAIL left_once: got %0d expected 0", nl);
    end
    for (int i = 0; i < 10; i++) begin
      btn_left = 1'b1;
      repeat (3) tick();
      btn_left = 1'b0;
      repeat (3) tick();
    end
    do_frame(nd, nl, nr, nsp, first);
    checks++;
    if (nl != 0) begin
      errors++; $display("FAIL bounce_left: got %0d expected 0", nl);
    end
  endtask

  task automatic test_cancel();
    int nd, nl, nr, nsp;
    logic [3:0] first;
    btn_left = 1'b1; btn_right = 1'b1;
    repeat (20) tick();
    btn_left = 1'b0; btn_right = 1'b0;
    repeat (12) tick();
    do_frame(nd, nl, nr, nsp, first);
    checks++;
    if (nl != 0 || nr != 0) begin
      errors++; $display("FAIL cancel_lr: got l=%0d r=%0d expected 0 0", nl, nr);
    end
    do_frame(nd, nl, nr, nsp, first);
    checks++;
    if (nl != 0 || nr != 0) begin
      errors++; $display("FAIL cancel_cleared: got l=%0d r=%0d expected 0 0", nl, nr);
    end
    btn_rot = 1'b1; btn_left = 1'b1;
    repeat (20) tick();
    btn_rot = 1'b0; btn_left = 1'b0;
    repeat (12) tick();
    do_frame(nd, nl, nr, nsp, first);
    checks++;
    if (first[2:0] !== 3'b101 || nl != 1 || nsp != 1) begin
      errors++;
      $display("FAIL rot_plus_left: got first=%b l=%0d sp=%0d expected 101 1 1", first[2:0], nl, nsp);
    end
  endtask

  task automatic test_back_to_back();
    int nd, nl, nr, nsp;
    logic [3:0] first;
    // The debounced rise lands 10 edges after the press, so pending is set
    // on the 11th edge, which is the frame_end edge.
    btn_left = 1'b1;
    repeat (10) tick();
    do_frame(nd, nl, nr, nsp, first);
    checks++;
    if (nl != 0) begin
      errors++; $display("FAIL coincident_same_frame: got %0d expected 0", nl);
    end
    do_frame(nd, nl, nr, nsp, first);
    checks++;
    if (nl != 1) begin
      errors++; $display("FAIL coincident_next_frame: got %0d expected 1", nl);
    end
    btn_left = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_reset_pending();
    int nd, nl, nr, nsp;
    logic [3:0] first;
    btn_rot = 1'b1; btn_right = 1'b1;
    repeat (20) tick();
    btn_rot = 1'b0;
    repeat (12) tick();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.s !== 4'd0) begin
      errors++; $display("FAIL midreset_s: got %0d expected 0", bus.s);
    end
    rst = 1'b0;
    repeat (15) tick();
    do_frame(nd, nl, nr, nsp, first);
    checks++;
    if (nsp != 0 || nr != 1) begin
      errors++;
      $display("FAIL reset_pending: got sp=%0d r=%0d expected sp=0 r=1", nsp, nr);
    end
    btn_right = 1'b0;
    repeat (12) tick();
  endtask

`ifdef FAST_DROP_EN
  task automatic test_fast_drop();
    int nd, nl, nr, nsp, exp_d;
    logic [3:0] first;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    bus.ns = 4'd2;
    do_frame(nd, nl, nr, nsp, first);
    btn_down = 1'b1;
    repeat (15) tick();
    for (int f = 1; f <= 6; f++) begin
      do_frame(nd, nl, nr, nsp, first);
      exp_d = (f % 2 == 0) ? 1 : 0;
      checks++;
      if (nd != exp_d) begin
        errors++; $display("FAIL fast_drop%0d: got %0d expected %0d", f, nd, exp_d);
      end
    end
    btn_down = 1'b0;
    repeat (15) tick();
    for (int f = 1; f <= 8; f++) begin
      do_frame(nd, nl, nr, nsp, first);
      exp_d = (f % 4 == 0) ? 1 : 0;
      checks++;
      if (nd != exp_d) begin
        errors++; $display("FAIL slow_drop%0d: got %0d expected %0d", f, nd, exp_d);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.frame_end = 1'b0;
    bus.ns = 4'd0;
    btn_left = 1'b0; btn_right = 1'b0; btn_rot = 1'b0;
`ifdef FAST_DROP_EN
    btn_down = 1'b0;
`endif
    test_reset();
    test_drop();
    test_move();
    test_cancel();
    test_back_to_back();
    test_reset_pending();
`ifdef FAST_DROP_EN
    test_fast_drop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
